// File: rtl/instr_fetch.sv
// Instruction fetch stage: holds the PC, fetches instruction words over a
// request/ready handshake, presents the current instruction to decode and
// selects the next PC (sequential, taken branch or jump) once it executes.
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [15:0] imm16,
   input  logic [31:0] imm_ext,
   input  logic        branch,
   input  logic        zero,
   input  logic        jump,
   input  logic        stall,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic [31:0] retired
);

   // Word alignment of the reset vector is enforced here so pc[1:0] stays 00.
   localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      EXEC
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [31:0] next_pc;
   logic [31:0] branch_target;
   logic [31:0] jump_target;
   logic        fetch_done;
   logic        exec_done;

   assign fetch_done = (state == FETCH) && imem_ready;
   assign exec_done  = (state == EXEC) && !stall;

   assign pc_plus4  = pc + 32'd4;
   assign imm16     = instr[15:0];
   assign imem_addr = pc;

   // The shift drops imm_ext[31:30], giving the word offset in bytes.
   assign branch_target = pc_plus4 + (imm_ext << 2);
   assign jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};

   // Next-PC selection: jump has priority over a taken branch.
   always_comb begin
      next_pc = pc_plus4;
      if (jump) begin
         next_pc = jump_target;
      end else if (branch && zero) begin
         next_pc = branch_target;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: IDLE -> FETCH, FETCH waits for ready, EXEC waits out stalls.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    state_next = FETCH;
         FETCH:   if (imem_ready) state_next = EXEC;
         EXEC:    if (!stall) state_next = FETCH;
         default: state_next = IDLE;
      endcase
   end

   // State-decoded outputs.
   always_comb begin
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      unique case (state)
         IDLE:    ;
         FETCH:   imem_req = 1'b1;
         EXEC:    instr_valid = 1'b1;
         default: ;
      endcase
   end

   // Datapath registers: capture the fetched word, advance PC and retire count.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc      <= RESET_PC_ALIGNED;
         instr   <= '0;
         retired <= '0;
      end else begin
         if (fetch_done) begin
            instr <= imem_rdata;
         end
         if (exec_done) begin
            pc      <= next_pc;
            retired <= retired + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized
// instruction streams, checked against a transaction-level PC model. Two
// instances share all inputs; the second starts at the top of the address space.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] imm_ext;
   logic        branch, zero, jump, stall;

   logic        req_a, valid_a, req_b, valid_b;
   logic [31:0] addr_a, instr_a, pc_a, p4_a, ret_a;
   logic [31:0] addr_b, instr_b, pc_b, p4_b, ret_b;
   logic [15:0] imm_a, imm_b;

   int unsigned vectors = 0;
   int unsigned errors  = 0;

   logic [31:0] exp_pc_a, exp_pc_b, exp_ret;

   localparam logic [31:0] RST_A = 32'h0040_0000;
   localparam logic [31:0] RST_B = 32'hFFFF_FFFC;

   always #5 clk = ~clk;

   instr_fetch dut_a (
      .clk(clk), .reset(reset), .imem_req(req_a), .imem_addr(addr_a),
      .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(instr_a),
      .instr_valid(valid_a), .imm16(imm_a), .imm_ext(imm_ext), .branch(branch),
      .zero(zero), .jump(jump), .stall(stall), .pc(pc_a), .pc_plus4(p4_a),
      .retired(ret_a)
   );

   instr_fetch #(.RESET_PC(RST_B)) dut_b (
      .clk(clk), .reset(reset), .imem_req(req_b), .imem_addr(addr_b),
      .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(instr_b),
      .instr_valid(valid_b), .imm16(imm_b), .imm_ext(imm_ext), .branch(branch),
      .zero(zero), .jump(jump), .stall(stall), .pc(pc_b), .pc_plus4(p4_b),
      .retired(ret_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] sext16(input logic [31:0] w);
      return {{16{w[15]}}, w[15:0]};
   endfunction

   // Architectural next-PC rule, computed with plain arithmetic.
   function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] w,
                                              input logic br, input logic z, input logic j);
      logic [31:0] p4;
      p4 = p + 32'd4;
      if (j) return {p4[31:28], w[25:0], 2'b00};
      if (br && z) return p4 + sext16(w) * 32'd4;
      return p4;
   endfunction

   // Inputs that must be ignored outside EXEC get random values.
   task automatic scramble_ctl();
      branch  = 1'($urandom);
      zero    = 1'($urandom);
      jump    = 1'($urandom);
      stall   = 1'($urandom);
      imm_ext = $urandom;
   endtask

   // One instruction from FETCH entry to retirement. Entered at a negedge with
   // both DUTs expected in FETCH; leaves at a negedge with both back in FETCH.
   task automatic run_instr(input int unsigned waits, input int unsigned stalls,
                            input logic br, input logic z, input logic j,
                            input logic [31:0] word);
      for (int unsigned k = 0; k <= waits; k++) begin
         chk("fetch_req_a", 32'(req_a), 32'd1);
         chk("fetch_addr_a", addr_a, exp_pc_a);
         chk("fetch_valid_a", 32'(valid_a), 32'd0);
         chk("fetch_retired_a", ret_a, exp_ret);
         chk("fetch_addr_b", addr_b, exp_pc_b);
         scramble_ctl();
         imem_ready = (k == waits);
         imem_rdata = (k == waits) ? word : $urandom;
         @(posedge clk);
         @(negedge clk);
      end
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      for (int unsigned s = 0; s <= stalls; s++) begin
         chk("exec_valid_a", 32'(valid_a), 32'd1);
         chk("exec_req_a", 32'(req_a), 32'd0);
         chk("exec_instr_a", instr_a, word);
         chk("exec_imm16_a", 32'(imm_a), {16'h0, word[15:0]});
         chk("exec_pc_a", pc_a, exp_pc_a);
         chk("exec_pc_plus4_a", p4_a, exp_pc_a + 32'd4);
         chk("exec_retired_a", ret_a, exp_ret);
         chk("exec_pc_b", pc_b, exp_pc_b);
         chk("exec_retired_b", ret_b, exp_ret);
         stall   = (s < stalls);
         branch  = br;
         zero    = z;
         jump    = j;
         imm_ext = sext16(word);
         imem_ready = 1'($urandom);
         @(posedge clk);
         @(negedge clk);
      end
      imem_ready = 1'b0;
      exp_pc_a = model_next(exp_pc_a, word, br, z, j);
      exp_pc_b = model_next(exp_pc_b, word, br, z, j);
      exp_ret  = exp_ret + 32'd1;
   endtask

   task automatic chk_reset_state();
      chk("rst_req_a", 32'(req_a), 32'd0);
      chk("rst_valid_a", 32'(valid_a), 32'd0);
      chk("rst_instr_a", instr_a, 32'd0);
      chk("rst_imm16_a", 32'(imm_a), 32'd0);
      chk("rst_pc_a", pc_a, RST_A);
      chk("rst_pc_plus4_a", p4_a, RST_A + 32'd4);
      chk("rst_retired_a", ret_a, 32'd0);
      chk("rst_pc_b", pc_b, RST_B);
      chk("rst_pc_plus4_b", p4_b, 32'd0);
   endtask

   initial begin
      reset = 1'b1; imem_ready = 1'b0; imem_rdata = '0; imm_ext = '0;
      branch = 1'b0; zero = 1'b0; jump = 1'b0; stall = 1'b0;
      exp_pc_a = RST_A; exp_pc_b = RST_B; exp_ret = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset_state();
      reset = 1'b0;
      imem_ready = 1'b1;            // ready while idle must be ignored
      @(posedge clk);
      @(negedge clk);
      chk("first_req_a", 32'(req_a), 32'd1);
      chk("first_instr_a", instr_a, 32'd0);

      // Sequential zero-wait fetch; dut_b wraps to address 0 on its second fetch.
      run_instr(0, 0, 1'b0, 1'b0, 1'b0, 32'h2000_0001);
      chk("wrap_addr_b", addr_b, 32'h0000_0000);
      run_instr(0, 0, 1'b0, 1'b0, 1'b0, 32'h2000_0002);
      run_instr(0, 0, 1'b0, 1'b0, 1'b0, 32'h2000_0003);
      chk("seq_retired_3", ret_a, 32'd3);
      chk("seq_addr_3", addr_a, 32'h0040_000C);

      // Backward branch, taken then not taken, each from pc 0x0040_0010.
      run_instr(0, 0, 1'b0, 1'b0, 1'b1, 32'h0810_0004);
      chk("jmp_to_10", pc_a, 32'h0040_0010);
      run_instr(0, 0, 1'b1, 1'b1, 1'b0, 32'h1000_FFFE);
      chk("br_taken", addr_a, 32'h0040_000C);
      run_instr(0, 0, 1'b0, 1'b0, 1'b1, 32'h0810_0004);
      run_instr(0, 0, 1'b1, 1'b0, 1'b0, 32'h1000_FFFE);
      chk("br_not_taken", addr_a, 32'h0040_0014);

      // Jump beats branch from pc 0x0040_0020.
      run_instr(0, 0, 1'b0, 1'b0, 1'b1, 32'h0810_0008);
      chk("jmp_to_20", pc_a, 32'h0040_0020);
      run_instr(0, 0, 1'b1, 1'b1, 1'b1, 32'h0810_0040);
      chk("jmp_beats_br", pc_a, 32'h0040_0100);

      // Three wait states then two stall cycles.
      run_instr(3, 2, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF);

      // Randomized instruction stream.
      for (int unsigned n = 0; n < 40; n++) begin
         run_instr($urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom),
                   1'($urandom), ($urandom_range(0, 5) == 0), $urandom);
      end

      // Reset during a FETCH wait, then a late ready pulse.
      chk("pre_rst_req_a", 32'(req_a), 32'd1);
      imem_ready = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk_reset_state();
      reset = 1'b0;
      imem_ready = 1'b1;
      imem_rdata = 32'hBAD0_BAD0;
      @(posedge clk);
      @(negedge clk);
      imem_ready = 1'b0;
      chk("late_ready_instr_a", instr_a, 32'd0);
      chk("late_ready_valid_a", 32'(valid_a), 32'd0);
      exp_pc_a = RST_A; exp_pc_b = RST_B; exp_ret = '0;
      run_instr(1, 0, 1'b0, 1'b0, 1'b0, 32'h1234_5678);
      chk("post_rst_retired_a", ret_a, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
